wash_phase_timer: RTL and testbench
===================================

WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clocks per timer tick, range 1..256.
REQ-002 SHALL have parameters DUR_FILL, DUR_WASH, DUR_DRAIN, DUR_RINSE, DUR_SPIN, defaults 15, 15, 15, 15, 15: phase lengths in ticks, range 1..255.
REQ-003 clk  in  1  clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 phase_valid  in  1  controller requests a phase.
REQ-006 phase_id  in  3  requested phase code, sampled only on handshake.
REQ-007 phase_ready  out  1  timer can accept a request.
REQ-008 pause  in  1  level signal that freezes counting.
REQ-009 abort  in  1  level signal that cancels the active phase.
REQ-010 busy  out  1  a phase is loaded (RUN or PAUSED).
REQ-011 remaining  out  8  ticks left in the current phase.
REQ-012 phase_done  out  1  one-cycle pulse at normal phase completion.
REQ-013 phase_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-015 phase_ready SHALL be 1 only in IDLE with abort=0; a handshake is phase_valid & phase_ready at a rising edge.
REQ-016 On handshake with phase_id 1..5, SHALL go to RUN, load remaining with the matching DUR_*, and clear the prescaler.
REQ-017 On handshake with phase_id 0, 6 or 7, SHALL stay IDLE, pulse phase_err for one cycle, and leave remaining at 0.
REQ-018 In RUN with pause=0, the prescaler SHALL increment each cycle, wrap from TICK_DIV-1 to 0, and decrement remaining on each wrap.
REQ-019 A wrap with remaining==1 SHALL move the block to DONE with remaining=0.
REQ-020 Without pause, phase_done SHALL go high at the (D*TICK_DIV)-th edge after the handshake edge, where D is the loaded duration.
REQ-021 DONE SHALL last exactly one cycle with phase_done=1, then return to IDLE.
REQ-022 RUN with pause=1 SHALL go to PAUSED with no decrement or prescaler advance that cycle; pause has priority over a wrap.
REQ-023 PAUSED SHALL hold the prescaler and remaining; pause=0 SHALL return to RUN and resume counting on the next edge.
REQ-024 abort=1 in RUN, PAUSED or DONE SHALL go to IDLE with remaining=0 and prescaler=0, suppressing phase_done; abort has priority over pause and wrap.
REQ-025 abort=1 in IDLE SHALL block handshakes (phase_ready=0).
REQ-026 phase_valid outside IDLE SHALL be ignored; there is no request queuing.
REQ-027 busy SHALL be 1 exactly in RUN and PAUSED.
REQ-028 remaining SHALL never wrap below 0.
REQ-029 All outputs SHALL be registered or decoded from the state register only.

Reset
REQ-030 reset SHALL asynchronously force IDLE, remaining=0, prescaler=0, phase_done=0, phase_err=0, busy=0.
REQ-031 After reset, phase_ready SHALL be 1 in the first cycle following deassertion (when abort=0).
REQ-032 Reset asserted mid-phase SHALL discard the phase with no phase_done pulse.

Structure
REQ-033 Shared package wash_pkg SHALL hold:
- phase codes: OFF=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6;
- the timer state enum;
- the 8-bit duration width constant.
REQ-034 The prescaler SHALL be a sub-module wash_tick_div with inputs clk, reset, run, clear and a one-cycle tick output.
REQ-035 The duration lookup SHALL be combinational inside wash_phase_timer.

Verification
REQ-036 TICK_DIV=4, DUR_WASH=3; handshake phase_id=2 -> phase_done pulses exactly 12 edges later, remaining goes 3,2,1,0, busy=1 throughout.
REQ-037 phase_id=7 handshake -> phase_err pulses one cycle, state stays IDLE, busy=0, phase_ready stays 1.
REQ-038 FILL run with pause high for 5 cycles mid-phase -> phase_done delayed by exactly 5 cycles, remaining frozen during the pause.
REQ-039 abort while PAUSED with remaining=2 -> next cycle IDLE, remaining=0, no phase_done pulse, phase_ready=1 once abort drops.
REQ-040 reset asserted mid-RUN without a clock edge -> outputs cleared immediately; a new SPIN handshake after release completes normally.
REQ-041 TICK_DIV=1, duration=1 -> phase_done at the first edge after the handshake; phase_valid held high during RUN/DONE causes no second load until IDLE.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the wash phase timer.
//   - phase_e       : phase codes presented on phase_id by the wash controller
//   - timer_state_e : state encoding of the phase timer FSM
//   - DUR_W         : width of phase durations and of the remaining-ticks count
package wash_pkg;

  localparam int DUR_W = 8;

  typedef enum logic [2:0] {
    PH_OFF   = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_DRAIN = 3'd3,
    PH_RINSE = 3'd4,
    PH_SPIN  = 3'd5,
    PH_DONE  = 3'd6
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } timer_state_e;

  // Only FILL..SPIN carry a duration; OFF, DONE and the unused code are rejected.
  function automatic logic phase_is_timed(input logic [2:0] id);
    return (id >= 3'(PH_FILL)) && (id <= 3'(PH_SPIN));
  endfunction

endpackage

// File: rtl/wash_tick_div.sv
// Tick prescaler for the wash phase timer.
// Counts 0..TICK_DIV-1 while run is high and raises tick for the one cycle in
// which the count wraps back to 0. clear returns the count to 0 and wins over run.
//   clk   in  clock, rising edge
//   reset in  asynchronous, active-high
//   run   in  advance the count this cycle
//   clear in  force the count to 0
//   tick  out one-cycle pulse on the cycle the count wraps
module wash_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Wash phase timer: accepts one phase request at a time from the wash
// controller, counts its duration down in prescaled ticks and reports
// completion or rejection with single-cycle pulses.
//   clk, reset      clock (rising edge) and asynchronous active-high reset
//   phase_valid/id  request handshake, phase_id sampled when phase_ready is high
//   phase_ready     high only in IDLE while abort is low
//   pause, abort    level controls; abort outranks pause, pause outranks a tick
//   busy            a phase is loaded (RUN or PAUSED)
//   remaining       ticks left in the current phase
//   phase_done      one-cycle pulse on normal completion
//   phase_err       one-cycle pulse when a request code is rejected
//
// state     | meaning
// ST_IDLE   | no phase loaded, waiting for a request
// ST_RUN    | phase loaded and counting
// ST_PAUSED | phase loaded, counting frozen by pause
// ST_DONE   | phase finished, phase_done high for this one cycle
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int DUR_FILL  = 15,
  parameter int DUR_WASH  = 15,
  parameter int DUR_DRAIN = 15,
  parameter int DUR_RINSE = 15,
  parameter int DUR_SPIN  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phase_valid,
  input  logic [2:0]       phase_id,
  output logic             phase_ready,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic [DUR_W-1:0] remaining,
  output logic             phase_done,
  output logic             phase_err
);

  timer_state_e     state_q, state_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic [DUR_W-1:0] dur_sel;
  logic             handshake;
  logic             loaded;
  logic             tick_run;
  logic             tick_clear;
  logic             tick;

  always_comb begin
    dur_sel = '0;
    case (phase_id)
      3'(PH_FILL):  dur_sel = DUR_W'(DUR_FILL);
      3'(PH_WASH):  dur_sel = DUR_W'(DUR_WASH);
      3'(PH_DRAIN): dur_sel = DUR_W'(DUR_DRAIN);
      3'(PH_RINSE): dur_sel = DUR_W'(DUR_RINSE);
      3'(PH_SPIN):  dur_sel = DUR_W'(DUR_SPIN);
      default:      dur_sel = '0;
    endcase
  end

  assign phase_ready = (state_q == ST_IDLE) && !abort;
  assign handshake   = phase_valid && phase_ready;
  assign loaded      = (state_q == ST_RUN) || (state_q == ST_PAUSED);

  // PAUSED counts on the same edge that sees pause drop, so a pause of N
  // cycles stretches the phase by exactly N cycles.
  assign tick_run   = loaded && !pause && !abort;
  assign tick_clear = handshake || abort;

  wash_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .run  (tick_run),
    .clear(tick_clear),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          if (phase_is_timed(phase_id)) begin
            state_d = ST_RUN;
            rem_d   = dur_sel;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN, ST_PAUSED: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_RUN;
          if (tick) begin
            // <= keeps the count from ever wrapping below zero
            if (rem_q <= DUR_W'(1)) begin
              state_d = ST_DONE;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign busy       = loaded;
  assign remaining  = rem_q;
  assign phase_done = (state_q == ST_DONE);
  assign phase_err  = err_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: instance A (TICK_DIV=4, distinct durations) is
// driven from a vector table with a completion scoreboard; instance B
// (TICK_DIV=1, duration 1) covers the shortest phase.
module tb_wash_phase_timer;
  import wash_pkg::*;

  localparam int TDA = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       va, pa, aa;
  logic [2:0] ida;
  logic       ready_a, busy_a, done_a, err_a;
  logic [7:0] rem_a;

  logic       vb, pb, ab;
  logic [2:0] idb;
  logic       ready_b, busy_b, done_b, err_b;
  logic [7:0] rem_b;

  wash_phase_timer #(
    .TICK_DIV(TDA), .DUR_FILL(2), .DUR_WASH(3), .DUR_DRAIN(5),
    .DUR_RINSE(4), .DUR_SPIN(2)
  ) dut_a (
    .clk(clk), .reset(reset), .phase_valid(va), .phase_id(ida),
    .phase_ready(ready_a), .pause(pa), .abort(aa), .busy(busy_a),
    .remaining(rem_a), .phase_done(done_a), .phase_err(err_a)
  );

  wash_phase_timer #(
    .TICK_DIV(1), .DUR_FILL(1), .DUR_WASH(1), .DUR_DRAIN(1),
    .DUR_RINSE(1), .DUR_SPIN(1)
  ) dut_b (
    .clk(clk), .reset(reset), .phase_valid(vb), .phase_id(idb),
    .phase_ready(ready_b), .pause(pb), .abort(ab), .busy(busy_b),
    .remaining(rem_b), .phase_done(done_b), .phase_err(err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int edge_no;
    bit is_err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [2:0] id;
    bit         err;
    int         dur;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc=%0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard: every done/err pulse from instance A must match the oldest
  // expectation, both in kind and in the edge at which it appears.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (!reset && (done_a || err_a)) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected at cyc=%0d: got done=%0b err=%0b, want no pulse",
                 cyc, done_a, err_a);
      end else begin
        e = sb_q.pop_front();
        chk("sb_edge", cyc, e.edge_no);
        chk("sb_kind_err", int'(err_a), int'(e.is_err));
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the handshake edge h.
  task automatic hs_a(input logic [2:0] id, input bit err, input int dur,
                      input int extra, input bit push, output int h);
    int w;
    exp_t e;
    w = 0;
    while (!ready_a && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_hs", int'(ready_a), 1);
    va  = 1'b1;
    ida = id;
    h   = cyc + 1;
    if (push) begin
      e.is_err  = err;
      e.edge_no = err ? h : h + dur * TDA + extra;
      sb_q.push_back(e);
    end
    @(negedge clk);
    va = 1'b0;
  endtask

  task automatic wait_idle_a();
    int w;
    w = 0;
    while ((busy_a || sb_q.size() != 0) && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_idle timeout at cyc=%0d: got busy=%0b pending=%0d, want idle",
               cyc, busy_a, sb_q.size());
    end
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int h;
    int froz;
    vecs[0] = '{3'd2, 1'b0, 3};
    vecs[1] = '{3'd7, 1'b1, 0};
    vecs[2] = '{3'd1, 1'b0, 2};
    vecs[3] = '{3'd0, 1'b1, 0};
    vecs[4] = '{3'd6, 1'b1, 0};
    vecs[5] = '{3'd5, 1'b0, 2};
    vecs[6] = '{3'd3, 1'b0, 5};
    vecs[7] = '{3'd4, 1'b0, 4};

    reset = 1'b1;
    va = 0; pa = 0; aa = 0; ida = 0;
    vb = 0; pb = 0; ab = 0; idb = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready_a", int'(ready_a), 1);
    chk("rst_busy_a",  int'(busy_a), 0);
    chk("rst_rem_a",   int'(rem_a), 0);
    chk("rst_done_a",  int'(done_a), 0);
    chk("rst_err_a",   int'(err_a), 0);
    chk("rst_ready_b", int'(ready_b), 1);
    chk("rst_busy_b",  int'(busy_b), 0);
    @(negedge clk);

    // Table-driven phases, with a per-cycle remaining/busy trace for timed ones.
    for (int i = 0; i < 8; i++) begin
      hs_a(vecs[i].id, vecs[i].err, vecs[i].dur, 0, 1'b1, h);
      if (vecs[i].err) begin
        chk("err_busy",  int'(busy_a), 0);
        chk("err_ready", int'(ready_a), 1);
        chk("err_rem",   int'(rem_a), 0);
        @(negedge clk);
        chk("err_one_cycle", int'(err_a), 0);
      end else begin
        for (int k = 0; k < vecs[i].dur * TDA; k++) begin
          chk("trace_rem",  int'(rem_a), vecs[i].dur - k / TDA);
          chk("trace_busy", int'(busy_a), 1);
          @(negedge clk);
        end
        chk("end_rem",  int'(rem_a), 0);
        chk("end_busy", int'(busy_a), 0);
      end
      wait_idle_a();
      @(negedge clk);
    end

    // Pause for 5 cycles on FILL, starting just before a tick would land.
    hs_a(3'd1, 1'b0, 2, 5, 1'b1, h);
    repeat (3) @(negedge clk);
    chk("pre_pause_rem", int'(rem_a), 2);
    froz = int'(rem_a);
    pa = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("pause_frozen_rem", int'(rem_a), froz);
      chk("pause_busy", int'(busy_a), 1);
    end
    pa = 1'b0;
    @(negedge clk);
    chk("post_pause_rem", int'(rem_a), 1);
    wait_idle_a();
    @(negedge clk);

    // Abort while PAUSED with remaining=2; no completion may follow.
    hs_a(3'd2, 1'b0, 3, 0, 1'b0, h);
    repeat (4) @(negedge clk);
    chk("abort_pre_rem", int'(rem_a), 2);
    pa = 1'b1;
    @(negedge clk);
    chk("abort_paused_busy", int'(busy_a), 1);
    aa = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_rem", int'(rem_a), 0);
    chk("abort_ready_blocked", int'(ready_a), 0);
    va = 1'b1; ida = 3'd1;
    @(negedge clk);
    chk("abort_blocks_hs", int'(busy_a), 0);
    va = 1'b0;
    aa = 1'b0; pa = 1'b0;
    #1;
    chk("abort_ready_back", int'(ready_a), 1);
    repeat (20) @(negedge clk);
    chk("abort_no_pending", sb_q.size(), 0);

    // Asynchronous reset mid-RUN, then a clean SPIN phase.
    hs_a(3'd3, 1'b0, 5, 0, 1'b0, h);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", int'(busy_a), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_rem", int'(rem_a), 0);
    chk("async_rst_done", int'(done_a), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", int'(ready_a), 1);
    hs_a(3'd5, 1'b0, 2, 0, 1'b1, h);
    wait_idle_a();
    @(negedge clk);

    // Instance B: TICK_DIV=1, duration 1, valid held through RUN/DONE.
    vb = 1'b1; idb = 3'd1;
    @(negedge clk);
    chk("b_run_busy", int'(busy_b), 1);
    chk("b_run_rem", int'(rem_b), 1);
    chk("b_run_ready", int'(ready_b), 0);
    @(negedge clk);
    chk("b_done_pulse", int'(done_b), 1);
    chk("b_done_busy", int'(busy_b), 0);
    chk("b_done_rem", int'(rem_b), 0);
    @(negedge clk);
    chk("b_idle_noreload", int'(busy_b), 0);
    chk("b_idle_done_low", int'(done_b), 0);
    chk("b_idle_ready", int'(ready_b), 1);
    vb = 1'b0;
    @(negedge clk);
    chk("b_stays_idle", int'(busy_b), 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
